// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit constants and helpers for the up/down counter.
//   BCD_MAX / BCD_MIN : digit limits
//   bcd_clamp(d)      : maps non-BCD nibbles (A..F) to 9
//   bcd_step(d, up)   : next digit value for one up or down step, wrapping 9<->0
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up);
        logic [3:0] nxt;
        if (up) begin
            nxt = (d >= BCD_MAX) ? BCD_MIN : d + 4'd1;
        end else begin
            nxt = (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one registered BCD decade.
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   clr         : synchronous clear to 0 (highest priority)
//   load/load_d : synchronous load of load_d, clamped to 9
//   step/up     : advance one step in the given direction
//   q           : current digit value
//   at_max      : q == 9
//   at_min      : q == 0
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_d,
    input  logic       step,
    input  logic       up,
    output logic [3:0] q,
    output logic       at_max,
    output logic       at_min
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = bcd_clamp(load_d);
        end else if (step) begin
            q_d = bcd_step(q_q, up);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign at_max = (q_q == BCD_MAX);
    assign at_min = (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: DIGITS-decade BCD up/down counter.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   clr      : synchronous clear (priority over load and en)
//   load     : synchronous load of load_val (digits > 9 clamp to 9)
//   load_val : BCD load value, digit i in [4i+3:4i]
//   en, up   : count enable and direction (1 = up)
//   count    : registered BCD value
//   tc       : combinational terminal count, en & (all 9 when up / all 0 when down)
//   wrap     : one-cycle registered pulse following a full wrap step
//   ovf      : sticky wrap flag, cleared by clr, load or rst
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                en,
    input  logic                up,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrap,
    output logic                ovf
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] step;
    // up_run[i] / dn_run[i]: every digit below i is at 9 / at 0.
    // Entry DIGITS covers the whole counter and drives tc.
    logic [DIGITS:0]   up_run;
    logic [DIGITS:0]   dn_run;

    logic wrap_q, wrap_d;
    logic ovf_q, ovf_d;

    always_comb begin
        up_run    = '0;
        dn_run    = '0;
        up_run[0] = 1'b1;
        dn_run[0] = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            up_run[i+1] = up_run[i] & at_max[i];
            dn_run[i+1] = dn_run[i] & at_min[i];
        end
    end

    always_comb begin
        step = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            step[i] = en & (up ? up_run[i] : dn_run[i]);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .load   (load),
            .load_d (load_val[4*g +: 4]),
            .step   (step[g]),
            .up     (up),
            .q      (count[4*g +: 4]),
            .at_max (at_max[g]),
            .at_min (at_min[g])
        );
    end

    assign tc = en & (up ? up_run[DIGITS] : dn_run[DIGITS]);

    // A wrap only counts when the step actually happens, i.e. clr and load
    // are not overriding it this cycle.
    always_comb begin
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (clr || load) begin
            ovf_d = 1'b0;
        end else if (tc) begin
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed self-checking bench for bcd_updown_counter
// with DIGITS = 3.
module tb_bcd_updown_counter;

    localparam int unsigned DIGITS = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                clr;
    logic                load;
    logic [4*DIGITS-1:0] load_val;
    logic                en;
    logic                up;
    logic [4*DIGITS-1:0] count;
    logic                tc;
    logic                wrap;
    logic                ovf;

    int tests  = 0;
    int failed = 0;

    bcd_updown_counter #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check_state(input string tag, input logic [11:0] c,
                               input logic w, input logic o);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".wrap"},  32'(wrap),  32'(w));
        check({tag, ".ovf"},   32'(ovf),   32'(o));
    endtask

    task automatic do_load(input logic [11:0] v);
        load = 1'b1; load_val = v; en = 1'b0;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;
        tick();
        tick();
        check_state("reset", 12'h000, 1'b0, 1'b0);
        check("reset.tc", 32'(tc), 32'd0);
        #3 rst = 1'b0;
        tick();

        // Full up run 000..999 then wrap.
        en = 1'b1; up = 1'b1;
        #1;
        for (int k = 0; k < 1000; k++) begin
            check("up.count", 32'(count), 32'(to_bcd(k)));
            check("up.tc",    32'(tc),    32'(k == 999));
            check("up.wrap",  32'(wrap),  32'd0);
            check("up.ovf",   32'(ovf),   32'd0);
            tick();
        end
        check_state("upwrap", 12'h000, 1'b1, 1'b1);
        check("upwrap.tc", 32'(tc), 32'd0);
        en = 1'b0;
        tick();
        check_state("hold", 12'h000, 1'b0, 1'b1);

        // Load 100 then count down twice.
        do_load(12'h100);
        check_state("ld100", 12'h100, 1'b0, 1'b0);
        en = 1'b1; up = 1'b0;
        tick();
        check_state("dn1", 12'h099, 1'b0, 1'b0);
        tick();
        check_state("dn2", 12'h098, 1'b0, 1'b0);
        en = 1'b0;

        // Down wrap from 000.
        do_load(12'h000);
        en = 1'b1; up = 1'b0;
        #1;
        check("dnwrap.tc", 32'(tc), 32'd1);
        tick();
        check_state("dnwrap", 12'h999, 1'b1, 1'b1);
        en = 1'b0;
        tick();
        check_state("dnhold", 12'h999, 1'b0, 1'b1);

        // Clamped load, wraps both ways, then clr suppressing a wrap.
        do_load(12'h9FA);
        check_state("clamp", 12'h999, 1'b0, 1'b0);
        en = 1'b1; up = 1'b1;
        tick();
        check_state("clamp.up", 12'h000, 1'b1, 1'b1);
        up = 1'b0;
        tick();
        check_state("clamp.dn", 12'h999, 1'b1, 1'b1);
        up = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b0;
        check_state("clr", 12'h000, 1'b0, 1'b0);

        // Load in the same cycle as a would-be wrap.
        do_load(12'h999);
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 12'h555;
        #1;
        check("ldwrap.tc", 32'(tc), 32'd1);
        tick();
        load = 1'b0; en = 1'b0;
        check_state("ldwrap", 12'h555, 1'b0, 1'b0);

        // Partial-digit clamp and mixed-direction steps.
        do_load(12'hA3C);
        check_state("clamp2", 12'h939, 1'b0, 1'b0);
        en = 1'b1; up = 1'b1;
        tick();
        check_state("mix.up", 12'h940, 1'b0, 1'b0);
        up = 1'b0;
        tick();
        check_state("mix.dn", 12'h939, 1'b0, 1'b0);

        // Reach 473 with ovf set, then asynchronous reset mid-cycle.
        en = 1'b0;
        do_load(12'h999);
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 474; k++) tick();
        check_state("pre_rst", 12'h473, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_state("async_rst", 12'h000, 1'b0, 1'b0);
        tick();
        check_state("rst_hold", 12'h000, 1'b0, 1'b0);
        #3 rst = 1'b0;
        tick();
        check_state("post_rst", 12'h001, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
